// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter: per-requester
// request/operand vectors toward the arbiter, grant and read-back data
// returned to the requesters.
interface regfile_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    REQ;
  logic [NREQ-1:0]    REQ_WR;
  logic [NREQ*AW-1:0] REQ_ADDR_A;
  logic [NREQ*AW-1:0] REQ_ADDR_B;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic [NREQ-1:0]    GNT;
  logic [DW-1:0]      RD_SRC;
  logic [DW-1:0]      RD_DEST;
  logic               ADDR_ERR;

  modport master (
    output REQ, REQ_WR, REQ_ADDR_A, REQ_ADDR_B, REQ_DATA,
    input  GNT, RD_SRC, RD_DEST, ADDR_ERR
  );

  modport slave (
    input  REQ, REQ_WR, REQ_ADDR_A, REQ_ADDR_B, REQ_DATA,
    output GNT, RD_SRC, RD_DEST, ADDR_ERR
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register file (two comb. reads, one write
// on ADDR_B) among NREQ requesters, with a sequencer that zeroes every entry.
// The winner is picked at a clock edge and issued during the following cycle.
module regfile_port_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  regfile_port_arbiter_if.slave bus,
  input  logic                  CLR_REQ,
  output logic                  CLR_BUSY,
  output logic                  CLR_DONE,
  output logic                  RF_WR,
  output logic [AW-1:0]         RF_ADDR_A,
  output logic [AW-1:0]         RF_ADDR_B,
  output logic [DW-1:0]         RF_DATA_IN,
  input  logic [DW-1:0]         RF_SRC,
  input  logic [DW-1:0]         RF_DEST
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CLEAR} state_t;

  state_t         state, state_nx;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  win_k;
  logic [PW-1:0]  sel_k;
  logic           sel_found;
  logic           sel_load;
  logic           win_wr;
  logic [AW-1:0]  win_addr_a;
  logic [AW-1:0]  win_addr_b;
  logic [DW-1:0]  win_data;
  logic [CW-1:0]  clr_cnt, clr_cnt_nx;
  logic           clr_done_q, clr_done_nx;
  logic [NREQ-1:0] gnt_oh;
  logic [NREQ-1:0] cand;
  logic           addr_err;

  // Current grant vector, and round-robin search from ptr over requesters
  // other than the one being issued this cycle
  always_comb begin
    int unsigned idx;
    idx = 0;
    gnt_oh = '0;
    if (state == S_ISSUE) gnt_oh[win_k] = 1'b1;
    cand = bus.REQ & ~gnt_oh;
    sel_found = 1'b0;
    sel_k = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!sel_found && cand[PW'(idx)]) begin
        sel_found = 1'b1;
        sel_k = PW'(idx);
      end
    end
  end

  // Out-of-range check on the latched operands
  always_comb begin
    addr_err = ({1'b0, win_addr_a} >= (AW+1)'(DEPTH)) ||
               ({1'b0, win_addr_b} >= (AW+1)'(DEPTH));
  end

  // Next-state and output decode; clear request always beats pending ops
  always_comb begin
    state_nx    = state;
    sel_load    = 1'b0;
    clr_cnt_nx  = clr_cnt;
    clr_done_nx = 1'b0;
    bus.GNT      = '0;
    bus.RD_SRC   = '0;
    bus.RD_DEST  = '0;
    bus.ADDR_ERR = 1'b0;
    CLR_BUSY   = 1'b0;
    CLR_DONE   = clr_done_q;
    RF_WR      = 1'b0;
    RF_ADDR_A  = '0;
    RF_ADDR_B  = '0;
    RF_DATA_IN = '0;
    case (state)
      S_IDLE: begin
        if (CLR_REQ) begin
          state_nx   = S_CLEAR;
          clr_cnt_nx = '0;
        end else if (sel_found) begin
          state_nx = S_ISSUE;
          sel_load = 1'b1;
        end
      end
      S_ISSUE: begin
        bus.GNT      = gnt_oh;
        bus.ADDR_ERR = addr_err;
        RF_ADDR_A    = win_addr_a;
        RF_ADDR_B    = win_addr_b;
        RF_DATA_IN   = win_data;
        RF_WR        = win_wr & ~addr_err;
        if (!addr_err) begin
          bus.RD_SRC  = RF_SRC;
          bus.RD_DEST = RF_DEST;
        end
        if (CLR_REQ) begin
          state_nx   = S_CLEAR;
          clr_cnt_nx = '0;
        end else if (sel_found) begin
          state_nx = S_ISSUE;
          sel_load = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_CLEAR: begin
        CLR_BUSY  = 1'b1;
        RF_WR     = 1'b1;
        RF_ADDR_B = AW'(clr_cnt);
        if (clr_cnt == CW'(DEPTH - 1)) begin
          state_nx    = S_IDLE;
          clr_done_nx = 1'b1;
          clr_cnt_nx  = '0;
        end else begin
          clr_cnt_nx = clr_cnt + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, pointer, clear counter and operand latch at the selection edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      ptr        <= '0;
      win_k      <= '0;
      win_wr     <= 1'b0;
      win_addr_a <= '0;
      win_addr_b <= '0;
      win_data   <= '0;
      clr_cnt    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      clr_done_q <= clr_done_nx;
      if (sel_load) begin
        win_k      <= sel_k;
        win_wr     <= bus.REQ_WR[sel_k];
        win_addr_a <= bus.REQ_ADDR_A[sel_k*AW +: AW];
        win_addr_b <= bus.REQ_ADDR_B[sel_k*AW +: AW];
        win_data   <= bus.REQ_DATA[sel_k*DW +: DW];
        ptr        <= (sel_k == PW'(NREQ - 1)) ? '0 : sel_k + PW'(1);
      end
    end
  end

endmodule
